// File: rtl/seq_det_mealy_param.sv
// Parametrised Mealy sequence detector with KMP fallback, optional overlap and a saturating hit counter.
// Define SEQ_DET_REG_OUT_EN to register OP (one cycle later, no combinational path from In to OP).
module seq_det_mealy_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
    parameter int                     OVERLAP     = 0,
    parameter int                     CNT_W       = 8,
    localparam int                    SW          = ($clog2(PATTERN_LEN) < 1) ? 1 : $clog2(PATTERN_LEN)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             In,
    input  logic             Clr,
    output logic             OP,
    output logic [SW-1:0]    State,
    output logic [CNT_W-1:0] Hit_Cnt
);

    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
        $fatal(1, "seq_det_mealy_param: PATTERN_LEN must be within 2..16");
    end

    // Pattern bit i in arrival order (bit 0 is the first bit received).
    function automatic int pat_bit(input int i);
        logic [PATTERN_LEN-1:0] sh;
        sh = PATTERN >> (PATTERN_LEN - 1 - i);
        return sh[0] ? 1 : 0;
    endfunction

    function automatic int seq_bit(input int m, input int k, input int b);
        return (m < k) ? pat_bit(m) : b;
    endfunction

    // Longest j <= jmax such that the first j pattern bits equal the last j bits
    // of the k matched pattern bits followed by b.
    function automatic int longest_border(input int k, input int b, input int jmax);
        int best;
        bit ok;
        best = 0;
        for (int j = 1; j <= jmax; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_bit(i) != seq_bit(k + 1 - j + i, k, b)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = j;
            end
        end
        return best;
    endfunction

    function automatic int next_state_of(input int k, input int b);
        if (k >= PATTERN_LEN) begin
            return 0;
        end
        if (b == pat_bit(k)) begin
            if (k < PATTERN_LEN - 1) begin
                return k + 1;
            end
            return (OVERLAP != 0) ? longest_border(k, b, PATTERN_LEN - 1) : 0;
        end
        return longest_border(k, b, k + 1);
    endfunction

    // Transition table resolved at elaboration; rows beyond PATTERN_LEN-1 are unreachable.
    logic [SW-1:0] next_tbl [0:(2**SW)-1][0:1];

    for (genvar k = 0; k < 2**SW; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NXT = next_state_of(k, b);
            assign next_tbl[k][b] = NXT[SW-1:0];
        end
    end

    logic hit;

    assign hit = En & (State == SW'(PATTERN_LEN - 1)) & (In == PATTERN[0]);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            State <= '0;
        end else if (En) begin
            State <= next_tbl[State][In];
        end
    end

    // Clear has priority over a coincident hit; the count sticks at all-ones.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Hit_Cnt <= '0;
        end else if (Clr) begin
            Hit_Cnt <= '0;
        end else if (hit && (Hit_Cnt != '1)) begin
            Hit_Cnt <= Hit_Cnt + 1'b1;
        end
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic op_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q <= 1'b0;
        end else begin
            op_q <= hit;
        end
    end

    assign OP = op_q;
`else
    assign OP = hit;
`endif

endmodule

// File: tb/tb_seq_det_mealy_param.sv
// Directed bench for seq_det_mealy_param: four instances share one stimulus stream.
// Expected OP timing follows SEQ_DET_REG_OUT_EN when it is defined at compile time.
module tb_seq_det_mealy_param;

    typedef struct {
        int en;
        int din;
        int clr;
        int hit;
        int st;
        int cnt;
    } vec_t;

    logic       clk, rst, en, din, clr;
    logic       op_a, op_b, op_c, op_d;
    logic [1:0] state_a, state_b, state_d;
    logic [2:0] state_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    int num_compared   = 0;
    int num_mismatched = 0;
    int prev_a, prev_b, prev_c, prev_d;
    int cum_a, cum_b;

    int s1   [17] = '{0,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0,0};
    int st_a1[17] = '{0,0,1,2,0,1,2,3,0,1,2,3,1,2,3,0,0};
    int h_a1 [17] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0};
    int st_b1[17] = '{0,0,1,2,0,1,2,3,2,3,2,3,1,2,3,2,0};
    int h_b1 [17] = '{0,0,0,0,0,0,0,0,1,0,1,0,0,0,0,1,0};

    int s3  [10] = '{1,1,0,1,1,0,1,1,1,0};
    int st3 [10] = '{1,2,3,4,2,3,4,2,2,3};
    int h3  [10] = '{0,0,0,0,1,0,0,1,0,0};

    vec_t v5 [28] = '{
        '{1,1,0,0,1,0}, '{1,0,0,0,2,0}, '{1,1,0,0,3,0},
        '{0,0,0,0,3,0}, '{0,1,0,0,3,0}, '{0,0,0,0,3,0},
        '{1,0,0,1,0,1},
        '{1,1,0,0,1,1}, '{1,0,0,0,2,1}, '{1,1,0,0,3,1}, '{1,0,0,1,0,2},
        '{1,1,0,0,1,2}, '{1,0,0,0,2,2}, '{1,1,0,0,3,2}, '{1,0,0,1,0,3},
        '{1,1,0,0,1,3}, '{1,0,0,0,2,3}, '{1,1,0,0,3,3}, '{1,0,0,1,0,3},
        '{1,1,0,0,1,3}, '{1,0,0,0,2,3}, '{1,1,0,0,3,3}, '{1,0,0,1,0,3},
        '{1,1,0,0,1,3}, '{1,0,0,0,2,3}, '{1,1,0,0,3,3},
        '{1,0,1,1,0,0}, '{1,0,0,0,0,0}
    };

    seq_det_mealy_param u_a (
        .Clk(clk), .Rst(rst), .En(en), .In(din), .Clr(clr),
        .OP(op_a), .State(state_a), .Hit_Cnt(cnt_a)
    );

    seq_det_mealy_param #(.OVERLAP(1)) u_b (
        .Clk(clk), .Rst(rst), .En(en), .In(din), .Clr(clr),
        .OP(op_b), .State(state_b), .Hit_Cnt(cnt_b)
    );

    seq_det_mealy_param #(.PATTERN_LEN(5), .PATTERN(5'b11011), .OVERLAP(1)) u_c (
        .Clk(clk), .Rst(rst), .En(en), .In(din), .Clr(clr),
        .OP(op_c), .State(state_c), .Hit_Cnt(cnt_c)
    );

    seq_det_mealy_param #(.CNT_W(2)) u_d (
        .Clk(clk), .Rst(rst), .En(en), .In(din), .Clr(clr),
        .OP(op_d), .State(state_d), .Hit_Cnt(cnt_d)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; OP is then sampled mid-cycle.
    task automatic applyStimulus(input int e, input int d, input int c);
        @(negedge clk);
        en  = (e != 0);
        din = (d != 0);
        clr = (c != 0);
        #2;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        prev_a = 0;
        prev_b = 0;
        prev_c = 0;
        prev_d = 0;
    endtask

    // A registered OP shows the previous edge's hit during the current cycle.
    function automatic int expOp(input int cur, input int prev);
`ifdef SEQ_DET_REG_OUT_EN
        return prev;
`else
        return cur;
`endif
    endfunction

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        prev_a = 0; prev_b = 0; prev_c = 0; prev_d = 0;
        #12;
        checkOutput("rst state_a", 32'(state_a), 0);
        checkOutput("rst state_b", 32'(state_b), 0);
        checkOutput("rst state_c", 32'(state_c), 0);
        checkOutput("rst state_d", 32'(state_d), 0);
        checkOutput("rst cnt_a", 32'(cnt_a), 0);
        checkOutput("rst cnt_d", 32'(cnt_d), 0);
        checkOutput("rst op_a", 32'(op_a), 0);
        checkOutput("rst op_c", 32'(op_c), 0);
        #3;
        rst = 1'b1;
        #1;

        // 1010 stream, non-overlapping (u_a) and overlapping (u_b) side by side
        cum_a = 0;
        cum_b = 0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, s1[i], 0);
            checkOutput($sformatf("s1 op_a bit%0d", i), 32'(op_a), expOp(h_a1[i], prev_a));
            checkOutput($sformatf("s1 op_b bit%0d", i), 32'(op_b), expOp(h_b1[i], prev_b));
            waitEdge();
            cum_a += h_a1[i];
            cum_b += h_b1[i];
            checkOutput($sformatf("s1 state_a bit%0d", i), 32'(state_a), st_a1[i]);
            checkOutput($sformatf("s1 state_b bit%0d", i), 32'(state_b), st_b1[i]);
            checkOutput($sformatf("s1 cnt_a bit%0d", i), 32'(cnt_a), cum_a);
            checkOutput($sformatf("s1 cnt_b bit%0d", i), 32'(cnt_b), cum_b);
            prev_a = h_a1[i];
            prev_b = h_b1[i];
        end
        applyStimulus(0, 0, 0);
        checkOutput("s1 op_a idle", 32'(op_a), expOp(0, prev_a));
        checkOutput("s1 op_b idle", 32'(op_b), expOp(0, prev_b));
        checkOutput("s1 cnt_a final", 32'(cnt_a), 2);
        checkOutput("s1 cnt_b final", 32'(cnt_b), 3);

        // Asynchronous reset in the middle of a partial match
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, (i == 1) ? 0 : 1, 0);
            waitEdge();
        end
        checkOutput("mid state_a before", 32'(state_a), 3);
        en  = 1'b1;
        din = 1'b0;
        #1;
        checkOutput("mid op_a before", 32'(op_a), expOp(1, 0));
        rst = 1'b0;
        #1;
        checkOutput("mid state_a in rst", 32'(state_a), 0);
        checkOutput("mid op_a in rst", 32'(op_a), 0);
        rst = 1'b1;
        applyStimulus(1, 0, 0);
        checkOutput("mid op_a after", 32'(op_a), 0);
        waitEdge();
        checkOutput("mid state_a after", 32'(state_a), 0);
        checkOutput("mid cnt_a after", 32'(cnt_a), 0);

        // Enable hold, saturation and clear-beats-hit on the 2-bit counter
        doReset();
        for (int i = 0; i < 28; i++) begin
            applyStimulus(v5[i].en, v5[i].din, v5[i].clr);
            checkOutput($sformatf("v5 op_d step%0d", i), 32'(op_d), expOp(v5[i].hit, prev_d));
            waitEdge();
            checkOutput($sformatf("v5 state_d step%0d", i), 32'(state_d), v5[i].st);
            checkOutput($sformatf("v5 cnt_d step%0d", i), 32'(cnt_d), v5[i].cnt);
            prev_d = v5[i].hit;
        end

        // 11011 overlapping, including the k=2 fallback on an extra 1
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, s3[i], 0);
            checkOutput($sformatf("s3 op_c bit%0d", i), 32'(op_c), expOp(h3[i], prev_c));
            waitEdge();
            checkOutput($sformatf("s3 state_c bit%0d", i), 32'(state_c), st3[i]);
            prev_c = h3[i];
        end
        checkOutput("s3 cnt_c final", 32'(cnt_c), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
